// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle IEEE-754 single-precision subtractor (result = op_a - op_b)
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   one-cycle request, only honoured in IDLE
//   op_a       in  32   minuend (IEEE-754 single)
//   op_b       in  32   subtrahend (IEEE-754 single)
//   result     out 32   registered difference, held until the next operation completes
//   done       out  1   one-cycle pulse while the freshly loaded result is presented
//   busy       out  1   high in every state except IDLE
//   overflow   out  1   sticky per operation, result saturated to infinity
//   underflow  out  1   sticky per operation, result flushed to zero
module fp_sub_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_SUB   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0]  MAX_A8  = 8'(MAX_ALIGN);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Mantissas carry one guard bit below the LSB: {hidden, frac[22:0], guard}.
    // The guard holds the last bit shifted out during alignment so a
    // subtraction that borrows across it still normalises to the right value;
    // it is dropped (truncated) when the result is packed.
    logic [2:0]  state_q, state_d;
    logic        big_s_q, big_s_d;
    logic [7:0]  big_e_q, big_e_d;
    logic [24:0] big_m_q, big_m_d;
    logic        small_s_q, small_s_d;
    logic [24:0] small_m_q, small_m_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [25:0] sum_q, sum_d;
    logic        nan_q, nan_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [7:0]  ea, eb, diff;
    logic [24:0] ma, mb;
    logic        a_big, is_nan;

    // Operand unpack; exponent 0 is treated as zero (denormals flushed).
    always_comb begin
        ea     = op_a[30:23];
        eb     = op_b[30:23];
        ma     = (ea != 8'd0) ? {1'b1, op_a[22:0], 1'b0} : 25'd0;
        mb     = (eb != 8'd0) ? {1'b1, op_b[22:0], 1'b0} : 25'd0;
        a_big  = (ea > eb) || ((ea == eb) && (ma >= mb));
        diff   = a_big ? (ea - eb) : (eb - ea);
        is_nan = (ea == 8'hFF) || (eb == 8'hFF);
    end

    always_comb begin
        state_d   = state_q;
        big_s_d   = big_s_q;
        big_e_d   = big_e_q;
        big_m_d   = big_m_q;
        small_s_d = small_s_q;
        small_m_d = small_m_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        nan_d     = nan_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // op_b's sign is inverted here, turning the job into an add.
                    if (a_big) begin
                        big_s_d   = op_a[31];
                        big_e_d   = ea;
                        big_m_d   = ma;
                        small_s_d = ~op_b[31];
                        small_m_d = mb;
                    end else begin
                        big_s_d   = ~op_b[31];
                        big_e_d   = eb;
                        big_m_d   = mb;
                        small_s_d = op_a[31];
                        small_m_d = ma;
                    end
                    // Special operands skip alignment entirely.
                    cnt_d   = is_nan ? 8'd0 : ((diff > MAX_A8) ? MAX_A8 : diff);
                    nan_d   = is_nan;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (cnt_q != 8'd0) begin
                    small_m_d = small_m_q >> 1;
                    cnt_d     = cnt_q - 8'd1;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                // big >= small in magnitude, so the difference never goes negative.
                if (big_s_q == small_s_q)
                    sum_d = {1'b0, big_m_q} + {1'b0, small_m_q};
                else
                    sum_d = {1'b0, big_m_q} - {1'b0, small_m_q};
                if (sum_d == 26'd0)
                    big_s_d = 1'b0;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (nan_q) begin
                    result_d = QNAN;
                    state_d  = S_DONE;
                end else if (sum_q[25]) begin
                    // Carry: one right shift lands the hidden bit at bit 24.
                    if (big_e_q == 8'd254) begin
                        result_d = {big_s_q, 8'hFF, 23'd0};
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = {big_s_q, big_e_q + 8'd1, sum_q[24:2]};
                    end
                    state_d = S_DONE;
                end else if (sum_q == 26'd0) begin
                    result_d = 32'd0;
                    state_d  = S_DONE;
                end else if (!sum_q[24]) begin
                    // Another left shift would take the exponent to 0 with the
                    // value still unnormalised: flush instead.
                    if (big_e_q <= 8'd1) begin
                        result_d = 32'd0;
                        unf_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        sum_d   = sum_q << 1;
                        big_e_d = big_e_q - 8'd1;
                    end
                end else begin
                    result_d = {big_s_q, big_e_q, sum_q[23:1]};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            big_s_q   <= 1'b0;
            big_e_q   <= 8'd0;
            big_m_q   <= 25'd0;
            small_s_q <= 1'b0;
            small_m_q <= 25'd0;
            cnt_q     <= 8'd0;
            sum_q     <= 26'd0;
            nan_q     <= 1'b0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            big_s_q   <= big_s_d;
            big_e_q   <= big_e_d;
            big_m_q   <= big_m_d;
            small_s_q <= small_s_d;
            small_m_q <= small_m_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            nan_q     <= nan_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // The result is loaded on the edge into DONE, so it is valid while done is high.
    assign result    = result_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb/tb_fp_sub_seq.sv - randomized self-checking bench for fp_sub_seq
module tb_fp_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [31:0] result;
    logic        done, busy, overflow, underflow;

    int total = 0;
    int bad = 0;

    fp_sub_seq #(.MAX_ALIGN(25)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .result(result), .done(done), .busy(busy),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: magnitudes as integers in units of 2^-24 of the leading bit
    // (one guard bit), alignment truncated by an integer shift capped at 25.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov,
                                  output logic uf, output int lat);
        int ea, eb, eg, es, e, n, sh;
        longint ma, mb, mg, ms, v;
        bit sa, sb, sg, ss;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = !b[31];
        ov = 1'b0;
        uf = 1'b0;
        n  = 0;
        if (ea == 255 || eb == 255) begin
            r = 32'h7FC00000;
            lat = 4;
            return;
        end
        ma = (ea != 0) ? ((longint'(1) << 24) + (longint'(a[22:0]) << 1)) : 0;
        mb = (eb != 0) ? ((longint'(1) << 24) + (longint'(b[22:0]) << 1)) : 0;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            eg = ea; mg = ma; sg = sa; es = eb; ms = mb; ss = sb;
        end else begin
            eg = eb; mg = mb; sg = sb; es = ea; ms = ma; ss = sa;
        end
        sh = (eg - es > 25) ? 25 : eg - es;
        ms = ms >> sh;
        v  = (sg == ss) ? mg + ms : mg - ms;
        e  = eg;
        if (v == 0) begin
            r = 32'd0;
        end else if (v >= (longint'(1) << 25)) begin
            if (e == 254) begin
                ov = 1'b1;
                r = {sg, 8'hFF, 23'd0};
            end else begin
                v = v >> 1;
                e = e + 1;
                r = {sg, 8'(e), 23'(v >> 1)};
            end
        end else begin
            while (v < (longint'(1) << 24)) begin
                if (e <= 1) begin
                    uf = 1'b1;
                    break;
                end
                v = v << 1;
                e = e - 1;
                n = n + 1;
            end
            r = uf ? 32'd0 : {sg, 8'(e), 23'(v >> 1)};
        end
        lat = sh + n + 4;
    endfunction

    // Issues one operation and reports what the DUT produced, its latency
    // (-1 on timeout) and whether busy stayed high until done then dropped.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic ov, output logic uf,
                          output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        r = 32'd0; ov = 1'b0; uf = 1'b0;
        @(negedge clk);
        op_a = a;
        op_b = b;
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                r = result; ov = overflow; uf = underflow;
                break;
            end
        end
        @(negedge clk);
        if (busy || done) busy_ok = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a, b, r;
        int lat;
        logic ov, uf;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [31:0] r, mr, a, b;
        logic ov, uf, mov, muf, bok;
        int lat, mlat, ndone, first_done;
        logic [31:0] seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, done, busy, overflow, underflow}, 32'd0);
        rst_n = 1'b1;

        dir.push_back('{32'h40400000, 32'h3F800000, 32'h40000000, 5, 1'b0, 1'b0});
        dir.push_back('{32'h3F800000, 32'hBF800000, 32'h40000000, 4, 1'b0, 1'b0});
        dir.push_back('{32'h3F800000, 32'h3FC00000, 32'hBF000000, 5, 1'b0, 1'b0});
        dir.push_back('{32'h3F800000, 32'h3F800000, 32'h00000000, 4, 1'b0, 1'b0});
        dir.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 1'b1, 1'b0});
        dir.push_back('{32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 29, 1'b0, 1'b0});
        dir.push_back('{32'h00800001, 32'h00800000, 32'h00000000, 4, 1'b0, 1'b1});
        dir.push_back('{32'h7F800000, 32'h3F800000, 32'h7FC00000, 4, 1'b0, 1'b0});
        dir.push_back('{32'h4C000000, 32'h3F800000, 32'h4C000000, 29, 1'b0, 1'b0});

        foreach (dir[i]) begin
            run_op(dir[i].a, dir[i].b, r, ov, uf, lat, bok);
            chk($sformatf("dir%0d_res", i), r, dir[i].r);
            chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir[i].lat));
            chk($sformatf("dir%0d_ovuf", i), {30'd0, ov, uf}, {30'd0, dir[i].ov, dir[i].uf});
            chk($sformatf("dir%0d_busy", i), {31'd0, bok}, 32'd1);
        end

        // start while busy and start in the DONE cycle are both ignored
        @(negedge clk);
        op_a = 32'h40400000;
        op_b = 32'h3F800000;
        start = 1'b1;
        ndone = 0;
        first_done = -1;
        seen = 32'd0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = k;
                    seen = result;
                end
            end
            start = (k == 2 || k == 5);
            if (k == 2) begin
                op_a = 32'h3F800000;
                op_b = 32'h3FC00000;
            end
        end
        chk("busy_start_res", seen, 32'h40000000);
        chk("busy_start_lat", 32'(first_done), 32'd5);
        chk("busy_start_ndone", 32'(ndone), 32'd1);

        // reset two cycles after start aborts without a done pulse
        @(negedge clk);
        op_a = 32'h4B800000;
        op_b = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {28'd0, done, busy, overflow, underflow}, 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run_op(32'h40400000, 32'h3F800000, r, ov, uf, lat, bok);
        chk("post_rst_res", r, 32'h40000000);
        chk("post_rst_lat", 32'(lat), 32'd5);

        // randomized operands against the model
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b[30:23] = a[30:23];
                1: b[30:23] = 8'(int'(a[30:23]) + int'($urandom_range(0, 4)) - 2);
                2: begin b = a; b[31] = $urandom_range(0, 1); b[3:0] = 4'($urandom); end
                default: ;
            endcase
            model(a, b, mr, mov, muf, mlat);
            run_op(a, b, r, ov, uf, lat, bok);
            chk($sformatf("rnd%0d_res %h-%h", i, a, b), r, mr);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d_ovuf", i), {30'd0, ov, uf}, {30'd0, mov, muf});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
